// File: rtl/parity_serial_tx.sv
// Serial transmitter for a 6-bit payload framed as start, six data bits
// (LSB first), a selectable even/odd parity bit and a stop bit. Every bit is
// held for CLKS_PER_BIT clocks. All outputs come straight from flops.
module parity_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] in_data,
    input  logic       in_odd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [5:0] data_q, data_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       bit_end_s;

    // Parity bit for a word: XOR of the data, inverted in odd mode.
    function automatic logic parity_bit(input logic [5:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Next-state logic, then outputs decoded from the next state so they register cleanly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_d     = par_q;
        bit_end_s = (cnt_q == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_START;
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    data_d  = in_data;
                    par_d   = parity_bit(in_data, in_odd);
                end else begin
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                end
            end
            ST_START, ST_PARITY, ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d = 8'd0;
                    case (state_q)
                        ST_START:  state_d = ST_DATA;
                        ST_PARITY: state_d = ST_STOP;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d = 8'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                idx_d   = 3'd0;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[idx_d];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_STOP) && (cnt_d == CNT_MAX);
    end

    // State, counters, payload latch and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 6'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/parity_serial_tx.md
PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_data  input  6  payload word to transmit.
REQ-005 Port: in_odd  input  1  parity mode: 0 = even, 1 = odd; sampled with in_data.
REQ-006 Port: in_valid  input  1  upstream offers in_data/in_odd.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: tx  output  1  serial line, idle high.
REQ-009 Port: busy  output  1  frame in progress.
REQ-010 Port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Frame SHALL be 9 bits in order: start (0), in_data[0]..in_data[5] LSB first, parity, stop (1).
REQ-012 Even mode: parity bit SHALL make the total count of ones across the 6 data bits plus parity even (parity = XOR of data bits).
REQ-013 Odd mode: parity bit SHALL make that total odd (parity = inverted XOR of data bits).
REQ-014 State machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 in_ready SHALL equal 1 only in IDLE and SHALL be a registered or state-decoded output with no combinational path from in_valid.
REQ-016 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data and in_odd are latched at that edge and the parity bit is computed from the latched value.
REQ-017 Changes to in_data or in_odd after acceptance SHALL NOT affect the frame in flight.
REQ-018 On acceptance the FSM SHALL enter START; tx SHALL go 0 in the first cycle after the accepting edge.
REQ-019 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that resets to 0 at every bit boundary.
REQ-020 DATA SHALL use a 3-bit index 0..5; it advances at each bit boundary and leaves for PARITY after index 5 completes.
REQ-021 Transitions: START->DATA, DATA->PARITY, PARITY->STOP, STOP->IDLE, each at the end of the current bit period.
REQ-022 A frame SHALL occupy exactly 9*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-023 done SHALL be 1 for exactly one cycle, the last cycle of the stop bit; busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 After STOP the FSM SHALL be in IDLE for at least one cycle with in_ready=1 and tx=1 before the next frame's start bit; back-to-back frames therefore have a gap of 1 cycle.
REQ-025 in_valid=1 while busy SHALL be ignored (no acceptance, no queuing).
REQ-026 With CLKS_PER_BIT=1 the block SHALL still meet REQ-022 and REQ-024.
REQ-027 tx, in_ready, busy and done SHALL be glitch-free registered or state-decoded outputs.

Reset
REQ-028 While rst_n=0, outputs SHALL be: state IDLE, tx=1, in_ready=1, busy=0, done=0; counters, bit index and the data latch SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously): tx returns high and no done pulse is produced.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge with in_valid=1.

Verification
REQ-031 Even frame, CLKS_PER_BIT=4: in_data=6'b101101, in_odd=0 -> tx = 0,1,0,1,1,0,1,0,1, each held 4 cycles; done pulses at cycle 36 after the accepting edge.
REQ-032 Odd frame: in_data=6'b000000, in_odd=1 -> parity bit 1; in_data=6'b111111, in_odd=1 -> parity bit 1; in_data=6'b000001, in_odd=1 -> parity bit 0.
REQ-033 Back-to-back: in_valid held high with two words -> exactly one IDLE cycle (tx=1, in_ready=1) between the stop bit of frame 1 and the start bit of frame 2; no word is dropped or duplicated.
REQ-034 Busy ignore and data stability: in_valid pulsed and in_data changed during DATA -> frame bits unchanged; no extra frame is sent.
REQ-035 Reset mid-frame: rst_n=0 during the bit at index 3 -> tx=1, busy=0, in_ready=1 at once; no done pulse; a new word sent after release is transmitted correctly.
REQ-036 CLKS_PER_BIT=1: in_data=6'b010011, in_odd=0 -> 9-cycle frame 0,1,1,0,0,1,0,1,1 and done on cycle 9.
